// File: rtl/spi_flash_streamer.sv
// spi_flash_streamer: SPI flash READ sequencer that shifts out command and address,
// then streams the requested number of received bytes as single-cycle strobes.
module spi_flash_streamer #(
   parameter int         AddrWidth = 24,
   parameter int         LenWidth  = 16,
   parameter logic [7:0] CmdRead   = 8'h03
) (
   input  logic                 sclk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [AddrWidth-1:0] req_addr,
   input  logic [LenWidth-1:0]  req_len,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 cs_n,
   output logic                 mosi,
   input  logic                 miso,
   output logic [7:0]           byte_data,
   output logic                 byte_valid
);
   localparam int SW = 7 + AddrWidth;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, END} state_t;

   state_t              state, state_d;
   logic [4:0]          cnt, cnt_d;
   logic [SW-1:0]       sh, sh_d;
   logic [7:0]          rx, rx_d, rx_next, byte_data_d;
   logic [LenWidth-1:0] left, left_d;
   logic                mosi_d, cs_n_d, busy_d, done_d, byte_valid_d;

   assign rx_next = {rx[6:0], miso};

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sh         <= '0;
         rx         <= '0;
         left       <= '0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         sh         <= sh_d;
         rx         <= rx_d;
         left       <= left_d;
         mosi       <= mosi_d;
         cs_n       <= cs_n_d;
         busy       <= busy_d;
         done       <= done_d;
         byte_data  <= byte_data_d;
         byte_valid <= byte_valid_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      sh_d         = sh;
      rx_d         = rx;
      left_d       = left;
      mosi_d       = mosi;
      cs_n_d       = cs_n;
      busy_d       = busy;
      done_d       = 1'b0;
      byte_data_d  = byte_data;
      byte_valid_d = 1'b0;
      case (state)
         IDLE: if (req && !abort) begin
            if (req_len == '0) state_d = END;
            else begin
               state_d = CMD;
               cnt_d   = '0;
               sh_d    = {CmdRead[6:0], req_addr};
               left_d  = req_len;
               busy_d  = 1'b1;
               cs_n_d  = 1'b0;
               mosi_d  = CmdRead[7];
            end
         end
         // cnt counts bits presented after the command MSB; SW of them finish address
         CMD, ADDR: begin
            mosi_d = sh[SW-1];
            sh_d   = sh << 1;
            cnt_d  = cnt + 5'd1;
            if (state == CMD && cnt == 5'd7) state_d = ADDR;
            if (cnt == 5'(SW)) begin
               state_d = DATA;
               cnt_d   = '0;
               mosi_d  = 1'b0;
            end
         end
         DATA: begin
            rx_d  = rx_next;
            cnt_d = cnt + 5'd1;
            if (cnt == 5'd7) begin
               cnt_d        = '0;
               byte_data_d  = rx_next;
               byte_valid_d = 1'b1;
               left_d       = left - 1'b1;
               if (left == LenWidth'(1)) begin
                  cs_n_d  = 1'b1;
                  state_d = END;
               end
            end
         end
         END: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort discards any byte completing on the same edge
      if (abort && (state == CMD || state == ADDR || state == DATA)) begin
         state_d      = END;
         cs_n_d       = 1'b1;
         mosi_d       = 1'b0;
         cnt_d        = '0;
         byte_valid_d = 1'b0;
         byte_data_d  = byte_data;
         left_d       = left;
      end
   end
endmodule

// File: tb/tb_spi_flash_streamer.sv
// tb_spi_flash_streamer: directed bench with a behavioural flash model and a
// scoreboard of expected byte strobes (value, cycle, chip-select state).
module tb_spi_flash_streamer;
   logic        sclk = 1'b0;
   logic        reset, req, abort, miso;
   logic [23:0] req_addr;
   logic [15:0] req_len;
   logic        busy, done, cs_n, mosi, byte_valid;
   logic [7:0]  byte_data;

   typedef struct {
      logic [7:0] d;
      int         when;
      logic       last;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          fcnt = 0;
   int          idx;
   int          t;
   logic [31:0] cap = '0;
   logic [7:0]  fdata [4];

   spi_flash_streamer dut (
      .sclk(sclk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
      .abort(abort), .busy(busy), .done(done), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .byte_data(byte_data), .byte_valid(byte_valid)
   );

   always #5 sclk = ~sclk;
   always @(posedge sclk) cyc <= cyc + 1;

   // flash: samples MOSI on rising edges while selected, returns fdata after 32 bits
   always @(posedge sclk) begin
      if (cs_n) fcnt <= 0;
      else begin
         fcnt <= fcnt + 1;
         if (fcnt < 32) cap <= {cap[30:0], mosi};
      end
   end

   always @(negedge sclk) begin
      idx  = fcnt - 32;
      miso = (!cs_n && fcnt >= 32 && idx < 32) ? fdata[idx / 8][7 - idx % 8] : 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge sclk) begin
      if (q.size() == 0) chk("stray_strobe", {31'd0, byte_valid}, 32'd0);
      else if (byte_valid) begin
         e = q.pop_front();
         chk("byte_data", {24'd0, byte_data}, {24'd0, e.d});
         chk("strobe_cyc", cyc, e.when);
         chk("cs_n_strobe", {31'd0, cs_n}, {31'd0, e.last});
      end
      if (!cs_n && fcnt > 32) chk("mosi_data", {31'd0, mosi}, 32'd0);
   end

   task automatic push(input logic [7:0] d, input int when, input logic last);
      q.push_back('{d, when, last});
   endtask

   task automatic start(input logic [23:0] a, input logic [15:0] n, output int ts);
      req_addr = a;
      req_len  = n;
      req      = 1'b1;
      @(negedge sclk);
      req = 1'b0;
      ts  = cyc;
      chk("cs_n_start", {31'd0, cs_n}, 32'd0);
      chk("busy_start", {31'd0, busy}, 32'd1);
      chk("mosi_cmd7", {31'd0, mosi}, 32'd0);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge sclk);
   endtask

   task automatic wait_done(input int exp, input logic [31:0] exp_cap);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge sclk);
         n++;
      end
      chk("done_cyc", cyc, exp);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("cs_n_end", {31'd0, cs_n}, 32'd1);
      chk("cmd_addr", cap, exp_cap);
      @(negedge sclk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("sb_empty", q.size(), 32'd0);
   endtask

   task automatic do_abort(input int at);
      wait_to(at - 1);
      abort = 1'b1;
      @(negedge sclk);
      abort = 1'b0;
      chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
      chk("abort_done0", {31'd0, done}, 32'd0);
      @(negedge sclk);
      chk("abort_done", {31'd0, done}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (60) @(negedge sclk);
      chk("abort_sb_empty", q.size(), 32'd0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; abort = 1'b0; req_addr = '0; req_len = '0;
      fdata = '{8'h00, 8'h00, 8'h00, 8'h00};
      repeat (3) @(negedge sclk);
      reset = 1'b0;
      repeat (10) @(negedge sclk);
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_valid", {31'd0, byte_valid}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_data", {24'd0, byte_data}, 32'd0);

      fdata = '{8'hA5, 8'h00, 8'h00, 8'h00};
      start(24'h012345, 16'd1, t);
      push(8'hA5, t + 40, 1'b1);
      wait_done(t + 41, 32'h03012345);

      fdata = '{8'h00, 8'hFF, 8'h5A, 8'h00};
      start(24'hABCDEF, 16'd3, t);
      push(8'h00, t + 40, 1'b0);
      push(8'hFF, t + 48, 1'b0);
      push(8'h5A, t + 56, 1'b1);
      wait_to(t + 20);
      req = 1'b1; req_addr = 24'h000000; req_len = 16'd5;
      @(negedge sclk);
      req = 1'b0;
      wait_done(t + 57, 32'h03ABCDEF);

      fdata = '{8'h77, 8'h88, 8'h00, 8'h00};
      start(24'h000100, 16'd2, t);
      do_abort(t + 20);

      fdata = '{8'h11, 8'h22, 8'h33, 8'h00};
      start(24'h000200, 16'd3, t);
      push(8'h11, t + 40, 1'b0);
      do_abort(t + 44);

      fdata = '{8'h96, 8'h00, 8'h00, 8'h00};
      start(24'hFFFFFF, 16'd1, t);
      push(8'h96, t + 40, 1'b1);
      wait_done(t + 41, 32'h03FFFFFF);

      req = 1'b1; req_len = 16'd0; req_addr = 24'h123456;
      @(negedge sclk);
      req = 1'b0;
      chk("len0_cs_n", {31'd0, cs_n}, 32'd1);
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_done0", {31'd0, done}, 32'd0);
      @(negedge sclk);
      chk("len0_done", {31'd0, done}, 32'd1);
      chk("len0_busy2", {31'd0, busy}, 32'd0);
      chk("len0_cs_n2", {31'd0, cs_n}, 32'd1);
      @(negedge sclk);
      chk("len0_done_end", {31'd0, done}, 32'd0);

      req = 1'b1; abort = 1'b1; req_len = 16'd4;
      @(negedge sclk);
      req = 1'b0; abort = 1'b0;
      repeat (3) begin
         chk("reqabort_cs_n", {31'd0, cs_n}, 32'd1);
         chk("reqabort_busy", {31'd0, busy}, 32'd0);
         chk("reqabort_done", {31'd0, done}, 32'd0);
         @(negedge sclk);
      end

      fdata = '{8'hDE, 8'hAD, 8'h00, 8'h00};
      start(24'h123456, 16'd2, t);
      wait_to(t + 36);
      #2 reset = 1'b1;
      #1;
      chk("arst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_mosi", {31'd0, mosi}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_valid", {31'd0, byte_valid}, 32'd0);
      chk("arst_data", {24'd0, byte_data}, 32'd0);
      @(negedge sclk);
      reset = 1'b0;
      repeat (2) @(negedge sclk);

      fdata = '{8'h3C, 8'hC3, 8'h00, 8'h00};
      start(24'h0F0F0F, 16'd2, t);
      push(8'h3C, t + 40, 1'b0);
      push(8'hC3, t + 48, 1'b1);
      wait_done(t + 49, 32'h030F0F0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_flash_streamer.md
# spi_flash_streamer

Read sequencer for the SPI flash holding the video data. On request it drives chip select, shifts out the READ command and a 24-bit address on MOSI, then deserializes a programmed number of bytes from MISO and presents each one as a single-cycle strobe to the downstream frame decoder. It runs entirely in the `sclk` domain, which is the SPI clock delivered to the flash, and it is the only master on that flash bus.

## Interface
- `AddrWidth`, default 24: flash address bits shifted after the command, MSB first.
- `LenWidth`, default 16: width of the byte-count request.
- `CmdRead`, default 8'h03: command byte sent first, MSB first.

Ports:
- `sclk` input 1: clock; all logic on posedge.
- `reset` input 1: asynchronous, active-high.
- `req` input 1: start a transfer; sampled only in IDLE.
- `req_addr` input AddrWidth: start address; latched when `req` is accepted.
- `req_len` input LenWidth: number of bytes to read; latched when `req` is accepted.
- `abort` input 1: terminate the current transfer.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle pulse when a transfer ends (normal or aborted).
- `cs_n` output 1: flash chip select, active-low.
- `mosi` output 1: serial command/address out.
- `miso` input 1: serial data in.
- `byte_data` output 8: last received byte, MSB-first assembly; holds its value between strobes.
- `byte_valid` output 1: one-cycle strobe; `byte_data` is valid while it is high.

## Operation
- The block has five states: IDLE, CMD, ADDR, DATA, END. All outputs are registered.
- Reset values: `cs_n`=1, `mosi`=0, `busy`=0, `done`=0, `byte_data`=0, `byte_valid`=0, state IDLE, all counters 0. Assertion takes effect immediately, including mid-transfer; `cs_n` rises asynchronously.
- **IDLE:**
  - `req`=1 with `req_len`≠0 and `abort`=0: latch address and length, set `busy`=1, `cs_n`=0, `mosi`=CmdRead[7], go to CMD.
  - `req`=1 with `req_len`=0: no bus activity; pulse `done` on the next cycle; `busy` stays 0.
  - `req` and `abort` in the same cycle: `abort` wins and `req` is dropped; no `done`.
- **CMD:** shift the remaining command bits, one per edge. After the eighth bit is presented, present address MSB and go to ADDR.
- **ADDR:** present AddrWidth bits, MSB first. After the last bit, go to DATA with the bit counter cleared. `mosi` is driven 0 during DATA.
- **DATA:**
  - Shift `miso` into an internal register, MSB first.
  - On every eighth bit, load `byte_data`, pulse `byte_valid`, and decrement the byte counter.
  - On the final byte's edge, also set `cs_n`=1 and go to END.
- **END:** pulse `done`, clear `busy`, go to IDLE.
- **`abort` in CMD, ADDR or DATA:** at that edge set `cs_n`=1 and go to END. A partially assembled byte is discarded and no `byte_valid` is produced. A byte completing on the abort edge is also discarded.
- `req` is ignored while `busy`=1. Latched address and length are unaffected by input changes mid-transfer.
- The byte counter is LenWidth bits, so the maximum transfer is 2^LenWidth − 1 bytes. The bit counter is 5 bits.

## Timing
- Let `req` be accepted at edge t.
- **Command/address phase:**
  - `cs_n` is low and `mosi`=CmdRead[7] from t. The flash samples command bits at edges t+1..t+8 and address bits at t+9..t+8+AddrWidth.
  - Each `mosi` value is stable for one full `sclk` period before the flash samples it.
- **Data phase** (with A=AddrWidth): the controller samples `miso` at edges t+9+A onward.
  - Byte k (k = 0..len−1) completes at edge t+8+A+8(k+1), where `byte_valid` rises for one cycle.
  - With defaults, byte 0 appears at t+40 and the last byte at t+32+8·len.
- **End of transfer:**
  - `cs_n` rises at the same edge as the last `byte_valid`.
  - `done`=1 and `busy`=0 at the following edge.
  - The earliest next accepted `req` is the edge after that, so `cs_n` is high for at least 2 cycles between transfers.
- **Abort:** abort at edge a gives `cs_n`=1 at a and `done` at a+1.

## Test plan
- Reset, then idle 10 cycles → `cs_n`=1, `busy`=0, `done`=0, `byte_valid`=0, `mosi`=0.
- `req`, addr=24'h012345, len=1; flash model returns 8'hA5 → MOSI bitstream 03 01 23 45; `byte_valid` only at t+40 with `byte_data`=8'hA5; `cs_n` rises at t+40; `done` at t+41.
- len=3 returning 8'h00, 8'hFF, 8'h5A → strobes at t+40, t+48, t+56 with values in order; a `req` asserted mid-transfer is ignored.
- `abort` at t+20 (ADDR phase), then again in another run at t+44 (mid byte 1) → no `byte_valid` after the abort; `cs_n` rises at the abort edge; `done` one cycle later; the next `req` is accepted normally.
- `req` with len=0 → no `cs_n` activity, `done` pulse one cycle later. `req` together with `abort` in IDLE → nothing happens.
- Assert `reset` asynchronously at t+37 → `cs_n`=1 immediately, all outputs at reset values; after release, a fresh len=2 transfer completes correctly.
